pipe_ctrl: RTL

Parametrised pipeline hazard controller for the CPU kernel, the successor to the fixed five-stage stall/flush logic. It produces per-stage stall and flush vectors for load-use hazards, branch-operand waits, multi-cycle EX operations and external memory stalls. A registered handshake FSM drives multi-cycle units with a single-cycle start pulse, and exceptions raised during an external stall are held pending instead of being dropped. It sits beside the datapath, feeding every pipeline register and the PC-select mux.

---
 rtl/pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller.
//
// Produces per-stage stall and flush vectors for load-use hazards,
// branch-operand waits, multi-cycle EX operations and external memory
// stalls. It also drives the PC redirect for exceptions and eret.
// A small handshake FSM issues a single-cycle start pulse to the
// multi-cycle unit. An exception raised while an external stall is active
// is held pending and fires in the first cycle the stall is released.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   : saturating stall-cycle and redirect counters are built
//   undefined : perf_stall_cyc / perf_flush_cnt are tied to 0
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   id_rs, id_rt           ID-stage source registers
//   ex_rmem, ex_rt         load in EX and its destination register
//   mem_rmem, mem_rt       load in MEM and its destination register
//   id_br_stall            branch in ID waiting on an operand
//   mc_req, mc_ready       multi-cycle op present in EX / result valid pulse
//   mc_start               one-cycle start pulse to the multi-cycle unit
//   ext_stall              external bus stall (IF or MEM)
//   exc_valid, exc_eret    exception / eret raised in MEM
//   exc_epc                CP0 EPC (eret target)
//   stall, flush           per-stage hold / bubble insert (index 0 = IF)
//   redirect_valid/_pc     PC redirect request and target
//   perf_stall_cyc         cycles with stall[0] asserted
//   perf_flush_cnt         redirect cycles

module pipe_ctrl #(
  parameter int          NSTAGE  = 5,
  parameter int          RW      = 5,
  parameter logic [31:0] EXC_VEC = 32'hBFC00380,
  parameter int          CNT_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              ex_rmem,
  input  logic              mem_rmem,
  input  logic [RW-1:0]     ex_rt,
  input  logic [RW-1:0]     mem_rt,
  input  logic              id_br_stall,
  input  logic              mc_req,
  input  logic              mc_ready,
  output logic              mc_start,
  input  logic              ext_stall,
  input  logic              exc_valid,
  input  logic              exc_eret,
  input  logic [31:0]       exc_epc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  mc_state_t          state_r;
  mc_state_t          state_nxt_s;

  logic               pend_v_r;
  logic               pend_eret_r;
  logic [31:0]        pend_epc_r;

  logic               lu_s;
  logic               mc_hold_s;
  logic               hold_s;
  logic               fire_s;
  logic               fire_eret_s;
  logic [31:0]        fire_epc_s;
  logic               flush_ex_s;
  logic               mc_start_s;
  logic [NSTAGE-1:0]  stall_s;
  logic [NSTAGE-1:0]  flush_s;
  logic [31:0]        redirect_pc_s;

  // Load-use hazard detection; register 0 is never a real dependency.
  always_comb begin
    lu_s = 1'b0;
    if (ex_rmem && (ex_rt != {RW{1'b0}}) && ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
      lu_s = 1'b1;
    end else if (mem_rmem && (mem_rt != {RW{1'b0}}) && ((mem_rt == id_rs) || (mem_rt == id_rt))) begin
      lu_s = 1'b1;
    end else begin
      lu_s = 1'b0;
    end
  end

  // Exception selection: a pending exception takes priority over a live one,
  // and nothing fires while the external stall is still asserted.
  always_comb begin
    fire_s      = 1'b0;
    fire_eret_s = 1'b0;
    fire_epc_s  = 32'h0000_0000;
    if (ext_stall) begin
      fire_s = 1'b0;
    end else if (pend_v_r) begin
      fire_s      = 1'b1;
      fire_eret_s = pend_eret_r;
      fire_epc_s  = pend_epc_r;
    end else if (exc_valid) begin
      fire_s      = 1'b1;
      fire_eret_s = exc_eret;
      fire_epc_s  = exc_epc;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Stall / flush vectors. DONE never holds; an exception overrides all.
  always_comb begin
    mc_hold_s = ((state_r == ST_IDLE) && mc_req) || ((state_r == ST_BUSY) && !mc_ready);
    hold_s    = mc_hold_s || ext_stall;
    stall_s   = {NSTAGE{1'b0}};
    flush_s   = {NSTAGE{1'b0}};
    if (fire_s) begin
      stall_s = {NSTAGE{1'b0}};
      flush_s = {NSTAGE{1'b1}};
    end else begin
      stall_s    = {NSTAGE{hold_s}};
      stall_s[0] = lu_s || id_br_stall || hold_s;
      stall_s[1] = lu_s || id_br_stall || hold_s;
      flush_s[2] = (lu_s || id_br_stall) && !hold_s;
    end
    // Any bubble into EX kills whatever multi-cycle op sat there.
    flush_ex_s = flush_s[2];
  end

  // Multi-cycle handshake next-state and start pulse.
  always_comb begin
    state_nxt_s = state_r;
    mc_start_s  = 1'b0;
    if (flush_ex_s) begin
      state_nxt_s = ST_IDLE;
      mc_start_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mc_req && !ext_stall) begin
            state_nxt_s = ST_BUSY;
            mc_start_s  = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mc_ready) begin
            state_nxt_s = ext_stall ? ST_DONE : ST_IDLE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (!ext_stall) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Multi-cycle FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending exception capture: latch during an external stall, clear on fire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_v_r    <= 1'b0;
      pend_eret_r <= 1'b0;
      pend_epc_r  <= 32'h0000_0000;
    end else if (fire_s) begin
      pend_v_r <= 1'b0;
    end else if (exc_valid && ext_stall && !pend_v_r) begin
      pend_v_r    <= 1'b1;
      pend_eret_r <= exc_eret;
      pend_epc_r  <= exc_epc;
    end else begin
      pend_v_r <= pend_v_r;
    end
  end

  // Output drive; everything is forced quiet while reset is asserted.
  always_comb begin
    redirect_pc_s = fire_eret_s ? fire_epc_s : EXC_VEC;
    if (resetn) begin
      stall          = stall_s;
      flush          = flush_s;
      mc_start       = mc_start_s;
      redirect_valid = fire_s;
      redirect_pc    = fire_s ? redirect_pc_s : 32'h0000_0000;
    end else begin
      stall          = {NSTAGE{1'b0}};
      flush          = {NSTAGE{1'b0}};
      mc_start       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall[0] && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (redirect_valid && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign perf_stall_cyc = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`else
  assign perf_stall_cyc = {CNT_W{1'b0}};
  assign perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
